// File: rtl/kmeans_centroid_sequencer.sv
// kmeans_centroid_sequencer
//   Initiator-side controller for a combinational double-precision point-ops
//   unit. Accumulates per-cluster (x,y) sums and point counts with ADD ops,
//   then, on finish, issues one DIV per cluster and emits the new centroids.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   io_in_valid/ready           point input handshake
//   io_in_x/y, io_in_idx        point coordinates (double) and cluster index
//   io_finish                   level request to compute centroids
//   io_op, io_p1x/y, io_p2x/y,
//   io_den                      command and operands to the point-ops unit
//   io_rx/ry                    same-cycle result from the point-ops unit
//   io_out_valid/ready          centroid output handshake
//   io_out_x/y, io_out_idx,
//   io_out_empty                centroid value, cluster, zero-count flag
//   io_drop                     pulse: accepted point had an out-of-range index
//   io_done                     pulse: last centroid has been taken
module kmeans_centroid_sequencer #(
    parameter int K     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [63:0]      io_in_x,
    input  logic [63:0]      io_in_y,
    input  logic [IDX_W-1:0] io_in_idx,
    input  logic             io_finish,
    output logic [3:0]       io_op,
    output logic [63:0]      io_p1x,
    output logic [63:0]      io_p1y,
    output logic [63:0]      io_p2x,
    output logic [63:0]      io_p2y,
    output logic [63:0]      io_den,
    input  logic [63:0]      io_rx,
    input  logic [63:0]      io_ry,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [63:0]      io_out_x,
    output logic [63:0]      io_out_y,
    output logic [IDX_W-1:0] io_out_idx,
    output logic             io_out_empty,
    output logic             io_drop,
    output logic             io_done
);

    localparam logic [3:0]  OP_NOP = 4'd0;
    localparam logic [3:0]  OP_ADD = 4'd1;
    localparam logic [3:0]  OP_DIV = 4'd3;
    localparam logic [63:0] DBL_ONE = 64'h3FF0000000000000;

    typedef enum logic [2:0] {
        S_ACCEPT,
        S_SUM,
        S_CNT,
        S_DIV,
        S_EMIT
    } state_t;

    state_t state_q, state_d;

    logic [63:0] acc_x_q [K];
    logic [63:0] acc_x_d [K];
    logic [63:0] acc_y_q [K];
    logic [63:0] acc_y_d [K];
    logic [63:0] cnt_q   [K];
    logic [63:0] cnt_d   [K];

    logic [63:0]      px_q, px_d;
    logic [63:0]      py_q, py_d;
    // cur holds the latched point's cluster during SUM/CNT and the
    // cluster being emitted during DIV/EMIT.
    logic [IDX_W-1:0] cur_q, cur_d;

    logic [63:0]      out_x_q, out_x_d;
    logic [63:0]      out_y_q, out_y_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic             out_empty_q, out_empty_d;
    logic             out_valid_q, out_valid_d;
    logic             drop_q, drop_d;
    logic             done_q, done_d;

    logic idx_oob;
    assign idx_oob = (32'(io_in_idx) >= 32'(K));

    assign io_out_valid = out_valid_q;
    assign io_out_x     = out_x_q;
    assign io_out_y     = out_y_q;
    assign io_out_idx   = out_idx_q;
    assign io_out_empty = out_empty_q;
    assign io_drop      = drop_q;
    assign io_done      = done_q;

    always_comb begin
        state_d     = state_q;
        acc_x_d     = acc_x_q;
        acc_y_d     = acc_y_q;
        cnt_d       = cnt_q;
        px_d        = px_q;
        py_d        = py_q;
        cur_d       = cur_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_idx_d   = out_idx_q;
        out_empty_d = out_empty_q;
        out_valid_d = out_valid_q;
        drop_d      = 1'b0;
        done_d      = 1'b0;
        io_in_ready = 1'b0;
        io_op       = OP_NOP;
        io_p1x      = '0;
        io_p1y      = '0;
        io_p2x      = '0;
        io_p2y      = '0;
        io_den      = '0;

        unique case (state_q)
            S_ACCEPT: begin
                io_in_ready = 1'b1;
                if (io_in_valid) begin
                    px_d  = io_in_x;
                    py_d  = io_in_y;
                    cur_d = io_in_idx;
                    if (idx_oob) drop_d  = 1'b1;
                    else         state_d = S_SUM;
                end else if (io_finish) begin
                    cur_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_SUM: begin
                io_op          = OP_ADD;
                io_p1x         = acc_x_q[cur_q];
                io_p1y         = acc_y_q[cur_q];
                io_p2x         = px_q;
                io_p2y         = py_q;
                acc_x_d[cur_q] = io_rx;
                acc_y_d[cur_q] = io_ry;
                state_d        = S_CNT;
            end
            S_CNT: begin
                // Count is incremented as a double: cnt + 1.0 through the x lane.
                io_op        = OP_ADD;
                io_p1x       = cnt_q[cur_q];
                io_p2x       = DBL_ONE;
                cnt_d[cur_q] = io_rx;
                state_d      = S_ACCEPT;
            end
            S_DIV: begin
                if (cnt_q[cur_q] == 64'h0) begin
                    out_x_d     = '0;
                    out_y_d     = '0;
                    out_empty_d = 1'b1;
                end else begin
                    io_op       = OP_DIV;
                    io_p1x      = acc_x_q[cur_q];
                    io_p1y      = acc_y_q[cur_q];
                    io_den      = cnt_q[cur_q];
                    out_x_d     = io_rx;
                    out_y_d     = io_ry;
                    out_empty_d = 1'b0;
                end
                out_idx_d   = cur_q;
                out_valid_d = 1'b1;
                state_d     = S_EMIT;
            end
            S_EMIT: begin
                if (io_out_ready) begin
                    out_valid_d    = 1'b0;
                    acc_x_d[cur_q] = '0;
                    acc_y_d[cur_q] = '0;
                    cnt_d[cur_q]   = '0;
                    if (cur_q == IDX_W'(K - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_ACCEPT;
                    end else begin
                        cur_d   = cur_q + 1'b1;
                        state_d = S_DIV;
                    end
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_ACCEPT;
            for (int unsigned i = 0; i < K; i++) begin
                acc_x_q[i] <= '0;
                acc_y_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
            px_q        <= '0;
            py_q        <= '0;
            cur_q       <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_idx_q   <= '0;
            out_empty_q <= 1'b0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_x_q     <= acc_x_d;
            acc_y_q     <= acc_y_d;
            cnt_q       <= cnt_d;
            px_q        <= px_d;
            py_q        <= py_d;
            cur_q       <= cur_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_idx_q   <= out_idx_d;
            out_empty_q <= out_empty_d;
            out_valid_q <= out_valid_d;
            drop_q      <= drop_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_kmeans_centroid_sequencer.sv
// Testbench for kmeans_centroid_sequencer (K=4, IDX_W=3 so that indices
// 4..7 exercise the drop path). A behavioural point-ops unit answers the
// DUT's commands; expected centroids come from per-cluster real sums/counts.
module tb_kmeans_centroid_sequencer;

    localparam int K     = 4;
    localparam int IDX_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_x = '0;
    logic [63:0]      in_y = '0;
    logic [IDX_W-1:0] in_idx = '0;
    logic             finish = 1'b0;
    logic [3:0]       op;
    logic [63:0]      p1x, p1y, p2x, p2y, den;
    logic [63:0]      rx, ry;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_x, out_y;
    logic [IDX_W-1:0] out_idx;
    logic             out_empty;
    logic             drop, done;

    int n_cmp = 0;
    int n_bad = 0;

    real m_sx [K];
    real m_sy [K];
    real m_cnt[K];

    always #5 clk = ~clk;

    kmeans_centroid_sequencer #(.K(K), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_x(in_x), .io_in_y(in_y), .io_in_idx(in_idx),
        .io_finish(finish),
        .io_op(op), .io_p1x(p1x), .io_p1y(p1y), .io_p2x(p2x), .io_p2y(p2y),
        .io_den(den), .io_rx(rx), .io_ry(ry),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_x(out_x), .io_out_y(out_y), .io_out_idx(out_idx),
        .io_out_empty(out_empty), .io_drop(drop), .io_done(done)
    );

    // Behavioural combinational point-ops unit.
    always_comb begin
        rx = '0;
        ry = '0;
        case (op)
            4'd1: begin
                rx = $realtobits($bitstoreal(p1x) + $bitstoreal(p2x));
                ry = $realtobits($bitstoreal(p1y) + $bitstoreal(p2y));
            end
            4'd2: begin
                rx = $realtobits($bitstoreal(p1x) - $bitstoreal(p2x));
                ry = $realtobits($bitstoreal(p1y) - $bitstoreal(p2y));
            end
            4'd3: begin
                rx = $realtobits($bitstoreal(p1x) / $bitstoreal(den));
                ry = $realtobits($bitstoreal(p1y) / $bitstoreal(den));
            end
            default: ;
        endcase
    end

    task automatic model_clear();
        for (int i = 0; i < K; i++) begin
            m_sx[i] = 0.0; m_sy[i] = 0.0; m_cnt[i] = 0.0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string who);
        int t;
        t = 0;
        while (!in_ready && t < 20) begin tick(); t++; end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for in_ready (got %b, need 1)", who, in_ready);
        end
    endtask

    task automatic send_point(input real x, input real y, input int idx);
        wait_in_ready("send_point");
        in_valid = 1'b1;
        in_x     = $realtobits(x);
        in_y     = $realtobits(y);
        in_idx   = IDX_W'(idx);
        tick();
        in_valid = 1'b0;
        if (idx >= K) begin
            n_cmp++;
            if (drop !== 1'b1) begin n_bad++; $display("FAIL drop_pulse: got %b need 1", drop); end
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL drop_ready: got %b need 1", in_ready); end
            tick();
            n_cmp++;
            if (drop !== 1'b0) begin n_bad++; $display("FAIL drop_width: got %b need 0", drop); end
        end else begin
            n_cmp++;
            if (drop !== 1'b0) begin n_bad++; $display("FAIL drop_spurious: got %b need 0", drop); end
            n_cmp++;
            if (op !== 4'd1 || p2x !== $realtobits(x) || in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL sum_cmd: op=%0d p2x=%h ready=%b need op=1 p2x=%h ready=0",
                         op, p2x, in_ready, $realtobits(x));
            end
            m_sx[idx] = m_sx[idx] + x;
            m_sy[idx] = m_sy[idx] + y;
            m_cnt[idx] = m_cnt[idx] + 1.0;
        end
    endtask

    task automatic start_finish();
        wait_in_ready("start_finish");
        finish = 1'b1;
        tick();
        finish = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL finish_enter: in_ready=%b need 0", in_ready); end
    endtask

    // Takes all K centroids; stall < 0 means a random 0..3 cycle stall each.
    task automatic collect(input int stall);
        logic [63:0] ex, ey, hx, hy;
        logic        ee;
        int          t, ns;
        for (int c = 0; c < K; c++) begin
            t = 0;
            while (!out_valid && t < 20) begin tick(); t++; end
            n_cmp++;
            if (!out_valid) begin
                n_bad++;
                $display("FAIL out_timeout: cluster %0d out_valid=%b need 1", c, out_valid);
                return;
            end
            if (m_cnt[c] == 0.0) begin ex = '0; ey = '0; ee = 1'b1; end
            else begin
                ex = $realtobits(m_sx[c] / m_cnt[c]);
                ey = $realtobits(m_sy[c] / m_cnt[c]);
                ee = 1'b0;
            end
            n_cmp++;
            if (out_idx !== IDX_W'(c) || out_x !== ex || out_y !== ey || out_empty !== ee) begin
                n_bad++;
                $display("FAIL centroid: got idx=%0d x=%h y=%h e=%b need idx=%0d x=%h y=%h e=%b",
                         out_idx, out_x, out_y, out_empty, c, ex, ey, ee);
            end
            hx = out_x; hy = out_y;
            ns = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int s = 0; s < ns; s++) begin
                tick();
                n_cmp++;
                if (out_valid !== 1'b1 || out_x !== hx || out_y !== hy ||
                    out_idx !== IDX_W'(c) || op !== 4'd0) begin
                    n_bad++;
                    $display("FAIL hold: v=%b x=%h y=%h idx=%0d op=%0d need v=1 x=%h y=%h idx=%0d op=0",
                             out_valid, out_x, out_y, out_idx, op, hx, hy, c);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b0 || done !== (c == K - 1)) begin
                n_bad++;
                $display("FAIL handshake: v=%b done=%b need v=0 done=%b", out_valid, done, (c == K - 1));
            end
            m_sx[c] = 0.0; m_sy[c] = 0.0; m_cnt[c] = 0.0;
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL after_done: done=%b ready=%b need done=0 ready=1", done, in_ready);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || drop !== 1'b0 || done !== 1'b0 ||
            op !== 4'd0 || out_x !== 64'h0 || out_y !== 64'h0 || out_idx !== '0 ||
            out_empty !== 1'b0 || p1x !== 64'h0 || den !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_state: rdy=%b v=%b drop=%b done=%b op=%0d ox=%h oy=%h idx=%0d e=%b need 1 0 0 0 0 0 0 0 0",
                     in_ready, out_valid, drop, done, op, out_x, out_y, out_idx, out_empty);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        send_point(1.0, 2.0, 0);
        send_point(3.0, 4.0, 0);
        start_finish();
        tick();
        n_cmp++;
        if (out_x !== 64'h4000000000000000 || out_y !== 64'h4008000000000000) begin
            n_bad++;
            $display("FAIL basic_const: x=%h y=%h need 4000000000000000 4008000000000000", out_x, out_y);
        end
        collect(0);
    endtask

    task automatic test_repeat_and_clear();
        for (int i = 0; i < 3; i++) send_point(2.0, 2.0, 2);
        start_finish();
        collect(-1);
        start_finish();
        collect(0);
    endtask

    task automatic test_drop();
        send_point(7.0, 7.0, 5);
        send_point(1.5, -2.5, 1);
        send_point(9.0, 9.0, 4);
        start_finish();
        collect(0);
    endtask

    task automatic test_stall();
        send_point(5.0, -3.0, 3);
        start_finish();
        collect(5);
    endtask

    task automatic test_valid_and_finish();
        wait_in_ready("valid_and_finish");
        in_valid = 1'b1;
        in_x = $realtobits(6.0);
        in_y = $realtobits(8.0);
        in_idx = '0;
        finish = 1'b1;
        tick();
        in_valid = 1'b0;
        m_sx[0] += 6.0; m_sy[0] += 8.0; m_cnt[0] += 1.0;
        n_cmp++;
        if (op !== 4'd1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL vf_sum: op=%0d ready=%b need 1 0", op, in_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL vf_accept: ready=%b need 1", in_ready); end
        tick();
        finish = 1'b0;
        n_cmp++;
        if (op !== 4'd3 || in_ready !== 1'b0 || den !== 64'h3FF0000000000000) begin
            n_bad++; $display("FAIL vf_div: op=%0d ready=%b den=%h need 3 0 3ff0000000000000", op, in_ready, den);
        end
        collect(0);
    endtask

    task automatic test_reset_midop();
        int t;
        wait_in_ready("reset_cnt");
        in_valid = 1'b1; in_x = $realtobits(4.0); in_y = $realtobits(4.0); in_idx = 3'd1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_cnt: ready=%b v=%b need 1 0", in_ready, out_valid);
        end
        send_point(3.0, 1.0, 2);
        start_finish();
        t = 0;
        while (!out_valid && t < 20) begin tick(); t++; end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_emit: ready=%b v=%b need 1 0", in_ready, out_valid);
        end
        start_finish();
        collect(0);
    endtask

    task automatic test_random();
        real x, y;
        int  idx;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 24; i++) begin
                x = real'(int'($urandom_range(0, 400))) / 4.0 - 50.0;
                y = real'(int'($urandom_range(0, 400))) / 8.0 - 20.0;
                idx = int'($urandom_range(0, 7));
                send_point(x, y, idx);
            end
            start_finish();
            collect(-1);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_basic();
        test_repeat_and_clear();
        test_drop();
        test_stall();
        test_valid_and_finish();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
